palette_colorizer: RTL and testbench

PALETTE_COLORIZER -- requirements
Module: palette_colorizer

---
 rtl/palette_colorizer_if.sv | 12 +
 rtl/palette_colorizer.sv | 135 +++++++++++++
 tb/tb_palette_colorizer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/palette_colorizer_if.sv
// Palette write port: valid/ready handshake carrying one 8-bit RRR_GGG_BB entry.
interface palette_colorizer_if #(
  parameter int PAL_AW = 4
);
  logic              pal_wr_valid;
  logic              pal_wr_ready;
  logic [PAL_AW-1:0] pal_wr_addr;
  logic [7:0]        pal_wr_data;

  modport master (output pal_wr_valid, pal_wr_addr, pal_wr_data, input pal_wr_ready);
  modport slave  (input pal_wr_valid, pal_wr_addr, pal_wr_data, output pal_wr_ready);
endinterface

// File: rtl/palette_colorizer.sv
// Palette-based pixel colourizer: world map plus prioritised, optionally blinking
// icon layers, resolved through a writable palette in a two-stage pixel pipeline.
module palette_colorizer #(
  parameter int NUM_ICONS    = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int PAL_AW       = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   video_on,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [1:0]             world_pixel,
  input  logic [2*NUM_ICONS-1:0] icon,
  input  logic [NUM_ICONS-1:0]   blink_en,
  palette_colorizer_if.slave     pal_wr,
  output logic                   pal_err,
  output logic [2:0]             red,
  output logic [2:0]             green,
  output logic [1:0]             blue,
  output logic                   hsync_out,
  output logic                   vsync_out
);
  localparam int NUM_ENT = 4 + 3*NUM_ICONS;
  localparam int CW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BLINK_FRAMES - 1);

  function automatic logic [7:0] pal_default(input int e);
    logic [7:0] val;
    if (e == 0)      val = 8'hFF;
    else if (e == 1) val = 8'h00;
    else if (e == 2) val = 8'hE0;
    else if (e == 3) val = 8'h92;
    else begin
      case ((e - 4) % 3)
        0:       val = 8'h80;
        1:       val = 8'h1F;
        default: val = 8'hE3;
      endcase
    end
    return val;
  endfunction

  logic [7:0]        pal [NUM_ENT];
  logic              ready_q;
  logic              wr_fire;
  logic              wr_in_range;
  logic              vs_prev;
  logic              frame_evt;
  logic [CW-1:0]     blink_cnt;
  logic              blink_phase;
  logic [1:0]        code;
  logic [PAL_AW-1:0] sel_idx;
  logic              von_s1;
  logic              hs_s1;
  logic              vs_s1;
  logic [7:0]        col_s1;

  // Ready drops combinationally with rst and stays low one cycle after release.
  assign pal_wr.pal_wr_ready = ready_q & ~rst;
  assign wr_fire     = pal_wr.pal_wr_valid & pal_wr.pal_wr_ready;
  assign wr_in_range = {1'b0, pal_wr.pal_wr_addr} < (PAL_AW+1)'(NUM_ENT);

  always_ff @(posedge clock) begin
    if (rst) begin
      ready_q <= 1'b0;
      pal_err <= 1'b0;
      for (int e = 0; e < NUM_ENT; e++) pal[e] <= pal_default(e);
    end else begin
      ready_q <= 1'b1;
      if (wr_fire && !wr_in_range) pal_err <= 1'b1;
      for (int e = 0; e < NUM_ENT; e++)
        if (wr_fire && pal_wr.pal_wr_addr == PAL_AW'(e)) pal[e] <= pal_wr.pal_wr_data;
    end
  end

  assign frame_evt = vs_prev & ~vsync_in;

  // Down-counter reloads at terminal count; each reload flips the blink phase.
  always_ff @(posedge clock) begin
    if (rst) begin
      vs_prev     <= 1'b1;
      blink_cnt   <= CNT_LOAD;
      blink_phase <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (frame_evt) begin
        if (blink_cnt == '0) begin
          blink_cnt   <= CNT_LOAD;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt - 1'b1;
        end
      end
    end
  end

  // Walk from the lowest-priority layer up so layer 0 overrides last.
  always_comb begin
    code    = 2'b00;
    sel_idx = PAL_AW'(world_pixel);
    for (int k = NUM_ICONS - 1; k >= 0; k--) begin
      code = icon[2*k +: 2];
      if (code != 2'b00 && !(blink_phase && blink_en[k]))
        sel_idx = PAL_AW'(4 + 3*k + int'(code) - 1);
    end
  end

  // Palette is read in the input cycle so a coincident write is not yet visible.
  always_ff @(posedge clock) begin
    if (rst) begin
      von_s1 <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      col_s1 <= 8'h00;
    end else begin
      von_s1 <= video_on;
      hs_s1  <= hsync_in;
      vs_s1  <= vsync_in;
      col_s1 <= pal[sel_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      {red, green, blue} <= 8'h00;
      hsync_out          <= 1'b1;
      vsync_out          <= 1'b1;
    end else begin
      {red, green, blue} <= von_s1 ? col_s1 : 8'h00;
      hsync_out          <= hs_s1;
      vsync_out          <= vs_s1;
    end
  end
endmodule

// File: tb/tb_palette_colorizer.sv
// Bench for palette_colorizer: vector table plus hand sequences, expected colours queued at drive time.
module tb_palette_colorizer;
  localparam int NI = 2;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          rst;
  logic          video_on;
  logic          hsync_in;
  logic          vsync_in;
  logic [1:0]    world_pixel;
  logic [2*NI-1:0] icon;
  logic [NI-1:0] blink_en;
  logic          pal_err;
  logic [2:0]    red;
  logic [2:0]    green;
  logic [1:0]    blue;
  logic          hsync_out;
  logic          vsync_out;

  palette_colorizer_if #(.PAL_AW(AW)) pal_wr ();

  palette_colorizer #(.NUM_ICONS(NI), .BLINK_FRAMES(2), .PAL_AW(AW)) dut (
    .clock(clock), .rst(rst), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .world_pixel(world_pixel), .icon(icon), .blink_en(blink_en), .pal_wr(pal_wr),
    .pal_err(pal_err), .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       von;
    logic [1:0] world;
    logic [3:0] icon;
    logic [1:0] blink;
    logic       hs;
    logic       vs;
    logic       wv;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_rst = 1'b1;
  logic err_exp = 1'b0;
  bit   primed = 1'b0;

  function automatic vec_t px(input logic von, input logic [1:0] w, input logic [3:0] ic,
                              input logic [7:0] e);
    vec_t v;
    v.rst = 1'b0; v.von = von; v.world = w; v.icon = ic; v.blink = 2'b00;
    v.hs = 1'b1; v.vs = 1'b1; v.wv = 1'b0; v.wa = 4'd0; v.wd = 8'h00; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    rst = v.rst; video_on = v.von; world_pixel = v.world; icon = v.icon; blink_en = v.blink;
    hsync_in = v.hs; vsync_in = v.vs;
    pal_wr.pal_wr_valid = v.wv; pal_wr.pal_wr_addr = v.wa; pal_wr.pal_wr_data = v.wd;
    #1;
    check("pal_wr_ready", {7'b0, pal_wr.pal_wr_ready}, {7'b0, !(v.rst || prev_rst)});
    if (primed) check("pal_err", {7'b0, pal_err}, {7'b0, err_exp});
    if (v.rst) begin
      foreach (sbq[i]) sbq[i] = '{8'h00, 1'b1, 1'b1};
      sbq.push_back('{8'h00, 1'b1, 1'b1});
    end else begin
      sbq.push_back('{v.exp, v.hs, v.vs});
    end
    @(posedge clock);
    if (v.rst) err_exp = 1'b0;
    else if (v.wv && !prev_rst && v.wa >= 4'd10) err_exp = 1'b1;
    prev_rst = v.rst;
    primed = 1'b1;
    @(negedge clock);
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      check("rgb", {red, green, blue}, e.rgb);
      check("hsync_out", {7'b0, hsync_out}, {7'b0, e.hs});
      check("vsync_out", {7'b0, vsync_out}, {7'b0, e.vs});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vec_t tbl[14];
    logic [7:0] exp_lo[4];
    logic [7:0] exp_hi[4];

    tbl[0]  = px(1'b1, 2'd0, 4'b0000, 8'hFF);
    tbl[1]  = px(1'b1, 2'd3, 4'b0000, 8'h92);
    tbl[2]  = px(1'b1, 2'd2, 4'b0000, 8'hE0);
    tbl[3]  = px(1'b1, 2'd1, 4'b0000, 8'h00);
    tbl[4]  = px(1'b1, 2'd0, 4'b1001, 8'h80);
    tbl[5]  = px(1'b1, 2'd0, 4'b1000, 8'h1F);
    tbl[6]  = px(1'b1, 2'd3, 4'b1100, 8'hE3);
    tbl[7]  = px(1'b1, 2'd3, 4'b0100, 8'h80);
    tbl[8]  = px(1'b1, 2'd0, 4'b0011, 8'hE3);
    tbl[9]  = px(1'b1, 2'd0, 4'b1110, 8'h1F);
    tbl[10] = px(1'b0, 2'd0, 4'b1001, 8'h00);
    tbl[11] = px(1'b1, 2'd0, 4'b0000, 8'hFF); tbl[11].hs = 1'b0;
    tbl[12] = px(1'b1, 2'd3, 4'b0000, 8'h92); tbl[12].hs = 1'b0; tbl[12].vs = 1'b0;
    tbl[13] = px(1'b0, 2'd3, 4'b0000, 8'h00);

    // power-on reset
    v = px(1'b0, 2'd0, 4'b0000, 8'h00); v.rst = 1'b1;
    repeat (3) step(v);

    for (int i = 0; i < 14; i++) step(tbl[i]);

    // write entry 5; coincident lookup sees old, next cycle sees new
    v = px(1'b1, 2'd0, 4'b0010, 8'h1F); v.wv = 1'b1; v.wa = 4'd5; v.wd = 8'h1C; step(v);
    step(px(1'b1, 2'd0, 4'b0010, 8'h1C));

    // last valid entry
    v = px(1'b1, 2'd0, 4'b0011, 8'hE3); v.wv = 1'b1; v.wa = 4'd9; v.wd = 8'h03; step(v);
    step(px(1'b1, 2'd0, 4'b1100, 8'h03));

    // out-of-range writes: flag set, palette untouched
    v = px(1'b1, 2'd0, 4'b0000, 8'hFF); v.wv = 1'b1; v.wa = 4'd10; v.wd = 8'h55; step(v);
    v.wa = 4'd15; v.wd = 8'hAA; step(v);
    step(px(1'b1, 2'd0, 4'b1100, 8'h03));
    step(px(1'b1, 2'd0, 4'b0010, 8'h1C));
    step(px(1'b1, 2'd0, 4'b0001, 8'h80));
    step(px(1'b1, 2'd2, 4'b0000, 8'hE0));

    // reset mid-stream with a write pending and hsync low
    v = px(1'b1, 2'd0, 4'b0001, 8'h00); v.rst = 1'b1; v.wv = 1'b1; v.wa = 4'd4; v.wd = 8'h11;
    v.hs = 1'b0; v.vs = 1'b0;
    step(v);
    step(v);
    step(px(1'b1, 2'd0, 4'b0001, 8'h80));
    step(px(1'b1, 2'd0, 4'b0010, 8'h1F));
    step(px(1'b1, 2'd0, 4'b1100, 8'hE3));
    step(px(1'b1, 2'd0, 4'b0000, 8'hFF));

    // blink: layer0 code 11 over white world, two frame events per half-period
    exp_lo = '{8'hE3, 8'hE3, 8'hFF, 8'hFF};
    exp_hi = '{8'hE3, 8'hFF, 8'hFF, 8'hE3};
    for (int f = 0; f < 4; f++) begin
      v = px(1'b1, 2'd0, 4'b0011, exp_lo[f]); v.blink = 2'b01; v.vs = 1'b0; step(v);
      v.vs = 1'b1; v.exp = exp_hi[f]; step(v);
    end
    for (int f = 0; f < 2; f++) begin
      v = px(1'b1, 2'd0, 4'b0011, 8'hE3); v.vs = 1'b0; step(v);
      v.vs = 1'b1; step(v);
    end
    // blink phase now active: check per-layer masking and fall-through
    v = px(1'b1, 2'd0, 4'b0111, 8'h80); v.blink = 2'b01; step(v);
    v = px(1'b1, 2'd0, 4'b0111, 8'hE3); v.blink = 2'b10; step(v);
    v = px(1'b1, 2'd0, 4'b0111, 8'hFF); v.blink = 2'b11; step(v);
    v = px(1'b1, 2'd0, 4'b0111, 8'hE3); v.blink = 2'b00; step(v);

    repeat (2) step(px(1'b0, 2'd0, 4'b0000, 8'h00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
